// File: rtl/trng_word_packer_if.sv
// Control and read-side bus between the TRNG register slave and the word packer.
// The slave modport is the packer; the master is the register block driving it.
interface trng_word_packer_if #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int OVF_W      = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic              enable;
    logic              raw_bit;
    logic              raw_valid;
    logic              clear_fail;
    logic              rd_pop;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic [LVL_W-1:0]  fifo_level;
    logic              health_fail;
    logic [OVF_W-1:0]  overflow_cnt;

    modport master (
        output enable, raw_bit, raw_valid, clear_fail, rd_pop,
        input  rd_data, rd_valid, fifo_level, health_fail, overflow_cnt
    );

    modport slave (
        input  enable, raw_bit, raw_valid, clear_fail, rd_pop,
        output rd_data, rd_valid, fifo_level, health_fail, overflow_cnt
    );
endinterface

// File: rtl/trng_word_packer.sv
// Repetition-count health test on raw entropy bits, packing of healthy bits into
// words, and a first-word-fall-through FIFO feeding the register read path.
module trng_word_packer #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RCT_CUTOFF = 8,
    parameter int OVF_W      = 16
) (
    input  logic               clock_i,
    input  logic               reset_i,
    trng_word_packer_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(WORD_W);
    localparam int RUN_W = $clog2(RCT_CUTOFF + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FAIL    = 2'd2
    } state_e;

    state_e            state_q;
    logic [WORD_W-2:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [RUN_W-1:0]  run_q;
    logic              prev_q;
    logic              hf_q;

    logic [WORD_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;
    logic [LVL_W-1:0]  level_q;
    logic [OVF_W-1:0]  ovf_q;

    logic              accept_d;
    logic [RUN_W-1:0]  run_d;
    logic              trip_d;
    logic              push_d;
    logic [WORD_W-1:0] word_d;
    logic              pop_d;
    logic              full_d;
    logic              wr_ok_d;
    logic              drop_d;

    // run_q == 0 marks "no bit accepted since entering COLLECT".
    always_comb begin
        run_d = RUN_W'(1);
        if (run_q != '0 && bus.raw_bit == prev_q)
            run_d = run_q + 1'b1;
    end

    assign accept_d = (state_q == COLLECT) && bus.enable && bus.raw_valid;
    assign trip_d   = accept_d && (run_d == RUN_W'(RCT_CUTOFF));
    assign word_d   = {shift_q, bus.raw_bit};
    assign push_d   = accept_d && !trip_d && (cnt_q == CNT_W'(WORD_W - 1));

    assign pop_d    = bus.rd_pop && (level_q != '0);
    assign full_d   = (level_q == LVL_W'(FIFO_DEPTH));
    assign wr_ok_d  = push_d && (!full_d || pop_d);
    assign drop_d   = push_d && full_d && !pop_d;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            run_q   <= '0;
            prev_q  <= 1'b0;
            hf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.enable)
                        state_q <= COLLECT;
                end
                COLLECT: begin
                    if (!bus.enable) begin
                        state_q <= IDLE;
                        shift_q <= '0;
                        cnt_q   <= '0;
                        run_q   <= '0;
                    end else if (trip_d) begin
                        state_q <= FAIL;
                        hf_q    <= 1'b1;
                        shift_q <= '0;
                        cnt_q   <= '0;
                    end else if (accept_d) begin
                        shift_q <= word_d[WORD_W-2:0];
                        prev_q  <= bus.raw_bit;
                        run_q   <= run_d;
                        cnt_q   <= push_d ? '0 : cnt_q + 1'b1;
                    end
                end
                FAIL: begin
                    if (bus.clear_fail) begin
                        state_q <= IDLE;
                        hf_q    <= 1'b0;
                        run_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // When full with a simultaneous pop, wptr equals rptr: the head is read
    // combinationally this cycle and overwritten on the edge.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= '0;
        end else begin
            if (wr_ok_d) begin
                fifo_q[wptr_q] <= word_d;
                wptr_q         <= wptr_q + 1'b1;
            end
            if (pop_d)
                rptr_q <= rptr_q + 1'b1;
            case ({wr_ok_d, pop_d})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (drop_d && ovf_q != '1)
                ovf_q <= ovf_q + 1'b1;
        end
    end

    assign bus.rd_data      = fifo_q[rptr_q];
    assign bus.rd_valid     = (level_q != '0);
    assign bus.fifo_level   = level_q;
    assign bus.health_fail  = hf_q;
    assign bus.overflow_cnt = ovf_q;
endmodule

// File: tb/tb_trng_word_packer.sv
// Directed and randomized checks of the word packer against a queue-based model.
module tb_trng_word_packer;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int RC = 8;
    localparam int OW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trng_word_packer_if #(.WORD_W(W), .FIFO_DEPTH(D), .OVF_W(OW)) bus ();

    trng_word_packer #(.WORD_W(W), .FIFO_DEPTH(D), .RCT_CUTOFF(RC), .OVF_W(OW)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 collect, 2 fail; hist holds bits accepted since entering collect.
    int           m_st;
    bit           hist[$];
    logic [W-1:0] m_w;
    int           m_cnt;
    logic [W-1:0] m_q[$];
    int           m_ovf;
    bit           m_hf;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(string tag);
        chk({tag, ".valid"}, 64'(bus.rd_valid), 64'(m_q.size() != 0));
        chk({tag, ".level"}, 64'(bus.fifo_level), 64'(m_q.size()));
        chk({tag, ".hf"}, 64'(bus.health_fail), 64'(m_hf));
        chk({tag, ".ovf"}, 64'(bus.overflow_cnt), 64'(m_ovf));
        if (m_q.size() != 0)
            chk({tag, ".data"}, 64'(bus.rd_data), 64'(m_q[0]));
    endtask

    task automatic model_reset();
        m_st = 0; hist.delete(); m_w = '0; m_cnt = 0;
        m_q.delete(); m_ovf = 0; m_hf = 0;
    endtask

    task automatic model_step();
        bit           pop_ok;
        bit           push;
        logic [W-1:0] pw;
        int           pre;
        int           r;
        pop_ok = bus.rd_pop && (m_q.size() > 0);
        push   = 0;
        pw     = '0;
        pre    = m_q.size();
        case (m_st)
            0: if (bus.enable) m_st = 1;
            1: begin
                if (!bus.enable) begin
                    m_st = 0; hist.delete(); m_cnt = 0; m_w = '0;
                end else if (bus.raw_valid) begin
                    r = 1;
                    for (int i = hist.size() - 1; i >= 0 && hist[i] == bus.raw_bit; i--) r++;
                    if (r >= RC) begin
                        m_hf = 1; m_st = 2; hist.delete(); m_cnt = 0; m_w = '0;
                    end else begin
                        hist.push_back(bus.raw_bit);
                        if (hist.size() > 2 * RC) void'(hist.pop_front());
                        m_w = m_w * 2 + W'(bus.raw_bit);
                        m_cnt++;
                        if (m_cnt == W) begin
                            push = 1; pw = m_w; m_cnt = 0; m_w = '0;
                        end
                    end
                end
            end
            default: if (bus.clear_fail) begin m_st = 0; m_hf = 0; end
        endcase
        if (pop_ok) void'(m_q.pop_front());
        if (push) begin
            if (pre < D || pop_ok) m_q.push_back(pw);
            else if (m_ovf < (1 << OW) - 1) m_ovf++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        bus.raw_valid  = 1'b0;
        bus.clear_fail = 1'b0;
        bus.rd_pop     = 1'b0;
    endtask

    task automatic send_bit(bit b);
        bus.raw_bit   = b;
        bus.raw_valid = 1'b1;
        tick();
    endtask

    task automatic send_word(logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic pop();
        bus.rd_pop = 1'b1;
        tick();
    endtask

    task automatic chk_zero(string tag);
        chk({tag, ".data"}, 64'(bus.rd_data), 64'h0);
        chk({tag, ".valid"}, 64'(bus.rd_valid), 64'h0);
        chk({tag, ".level"}, 64'(bus.fifo_level), 64'h0);
        chk({tag, ".hf"}, 64'(bus.health_fail), 64'h0);
        chk({tag, ".ovf"}, 64'(bus.overflow_cnt), 64'h0);
    endtask

    initial begin
        logic [W-1:0] exp_order [4];
        logic [W-1:0] nw;
        bus.enable = 0; bus.raw_bit = 0; bus.raw_valid = 0;
        bus.clear_fail = 0; bus.rd_pop = 0;
        model_reset();
        #3;
        chk_zero("reset");
        #9 rst = 1'b0;

        // 1: first word, zero-latency visibility
        bus.enable = 1'b1;
        tick();
        send_word(32'hAAAA_AAAA);
        chk("t1.data", 64'(bus.rd_data), 64'hAAAA_AAAA);
        chk("t1.level", 64'(bus.fifo_level), 64'd1);
        chk_all("t1");

        // 2: overflow then drain in order
        pop();
        repeat (5) send_word(32'hAAAA_AAAA);
        chk("t2.level", 64'(bus.fifo_level), 64'd4);
        chk("t2.ovf", 64'(bus.overflow_cnt), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("t2.rd", 64'(bus.rd_data), 64'hAAAA_AAAA);
            pop();
        end
        chk("t2.empty", 64'(bus.rd_valid), 64'd0);
        pop();
        chk("t2.popempty", 64'(bus.fifo_level), 64'd0);
        chk_all("t2");

        // 3: health trip, ignore in FAIL, clear and resume
        send_word(32'hAAAA_AAAA);
        repeat (7) send_bit(1'b1);
        chk("t3.hf7", 64'(bus.health_fail), 64'd0);
        send_bit(1'b1);
        chk("t3.hf8", 64'(bus.health_fail), 64'd1);
        chk("t3.level", 64'(bus.fifo_level), 64'd1);
        bus.enable = 1'b0;
        send_word(32'h5A5A_5A5A);
        chk("t3.ignored", 64'(bus.fifo_level), 64'd1);
        chk("t3.hfstay", 64'(bus.health_fail), 64'd1);
        bus.enable = 1'b1;
        bus.clear_fail = 1'b1;
        tick();
        chk("t3.clr", 64'(bus.health_fail), 64'd0);
        tick();
        send_word(32'hAAAA_AAAA);
        chk("t3.level2", 64'(bus.fifo_level), 64'd2);
        chk_all("t3");
        pop(); pop();

        // 4: partial word discarded on enable drop
        for (int i = 0; i < 16; i++) send_bit(i % 2 == 0);
        bus.enable = 1'b0; tick();
        bus.enable = 1'b1; tick();
        send_word(32'h5555_5555);
        chk("t4.level", 64'(bus.fifo_level), 64'd1);
        chk("t4.data", 64'(bus.rd_data), 64'h5555_5555);

        // 5: completion coinciding with pop while full
        repeat (3) send_word(32'h1234_5678);
        nw = 32'h36C9_A5D2;
        for (int i = W - 1; i >= 1; i--) send_bit(nw[i]);
        bus.rd_pop = 1'b1;
        send_bit(nw[0]);
        chk("t5.level", 64'(bus.fifo_level), 64'd4);
        chk("t5.ovf", 64'(bus.overflow_cnt), 64'd1);
        exp_order[0] = 32'h1234_5678; exp_order[1] = 32'h1234_5678;
        exp_order[2] = 32'h1234_5678; exp_order[3] = nw;
        for (int i = 0; i < 4; i++) begin
            chk("t5.order", 64'(bus.rd_data), 64'(exp_order[i]));
            pop();
        end
        chk_all("t5");

        // 6: async reset mid-word, then mid-FAIL
        repeat (3) send_word(32'h1234_5678);
        repeat (5) begin send_bit(1'b1); send_bit(1'b0); end
        #2 rst = 1'b1;
        #1 chk_zero("t6a");
        model_reset();
        @(negedge clk) rst = 1'b0;
        tick();
        repeat (3) send_word(32'h1234_5678);
        repeat (RC) send_bit(1'b1);
        chk("t6.hf", 64'(bus.health_fail), 64'd1);
        #2 rst = 1'b1;
        #1 chk_zero("t6b");
        model_reset();
        @(negedge clk) rst = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.enable     = ($urandom_range(0, 49) != 0);
            bus.raw_valid  = ($urandom_range(0, 3) != 0);
            bus.raw_bit    = 1'($urandom);
            bus.rd_pop     = (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
            bus.clear_fail = (m_st == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            tick();
            chk_all("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trng_word_packer.md
Name: trng_word_packer

Overview:
Entropy conditioning stage that sits directly upstream of the TRNG AXI-lite register slave. It accepts synchronized raw bits from the ring-oscillator sampler and runs a repetition-count health test on them. Healthy bits are packed into 32-bit words and buffered in a small first-word-fall-through FIFO. The AXI-lite read path pops words from the FIFO and exposes level, health and overflow status in its registers.

Parameters:
WORD_W, 32, packed word width in bits
FIFO_DEPTH, 4, number of word entries (power of 2, >=2)
RCT_CUTOFF, 8, run length of identical bits that trips the health test (>=2)
OVF_W, 16, overflow counter width

Ports:
clock  in  1  single system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  packing enable, driven from control register bit 0
raw_bit  in  1  sampled entropy bit, already synchronized to clock
raw_valid  in  1  raw_bit is valid this cycle
clear_fail  in  1  single-cycle pulse; clears health_fail
rd_pop  in  1  single-cycle pulse; consume FIFO head
rd_data  out  WORD_W  FIFO head word, valid when rd_valid=1
rd_valid  out  1  FIFO non-empty
fifo_level  out  clog2(FIFO_DEPTH)+1  current number of entries
health_fail  out  1  sticky repetition-count failure flag
overflow_cnt  out  OVF_W  count of completed words dropped because the FIFO was full

Behaviour:
- Reset (async, active-high): all outputs are 0; FIFO is empty; shift register, bit count and run length are 0; FSM goes to IDLE.
- Accepted bit: raw_valid=1 in state COLLECT.
- FSM states are IDLE, COLLECT and FAIL.
  - IDLE -> COLLECT when enable=1.
  - COLLECT -> IDLE when enable=0. The partial word is discarded; bit count and run length return to 0.
  - COLLECT -> FAIL when the health test trips.
  - FAIL -> IDLE on clear_fail=1.
  - clear_fail in any state other than FAIL is ignored.
- Packing: shift left, with the new bit entering the LSB. The first accepted bit of a word ends up in bit WORD_W-1.
- Word completion: the WORD_W-th accepted bit completes the word. On that same edge the full word is written to the FIFO and the bit count returns to 0.
  - Zero-latency packing: the word appears on rd_data on the next cycle if the FIFO was empty.
- Health test:
  - run_len is 1 for the first accepted bit after entering COLLECT.
  - Each later bit: run_len+1 if it equals the previous accepted bit, else 1.
  - The bit that would make run_len equal RCT_CUTOFF is not packed. On that edge health_fail is set to 1, the partial word is discarded, the bit count is cleared, and the FSM enters FAIL.
- FAIL: no bits are accepted and no FIFO writes occur. FIFO contents stay readable.
- health_fail stays 1 until clear_fail is seen in FAIL; it clears on that edge. The run length also resets.
- FIFO behaviour:
  - First-word fall-through: rd_data is combinationally the head entry; rd_valid = (fifo_level != 0).
  - rd_pop when empty is ignored.
  - Write when full with no pop in the same cycle: the word is dropped and overflow_cnt increments, saturating at all-ones.
  - Write and pop in the same cycle when full: both succeed and fifo_level is unchanged.
  - Write and pop in the same cycle when empty: the write succeeds, the pop is ignored, and fifo_level becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow_cnt is cleared only by reset.
- enable deasserted in FAIL has no effect; only clear_fail leaves FAIL.
- FIFO contents survive IDLE and FAIL; only reset empties the FIFO.

Test Plan:
1. Reset release, then enable=1 and 32 alternating bits 1,0,1,0... with raw_valid=1 -> one cycle after the 32nd bit: rd_valid=1, rd_data=0xAAAAAAAA, fifo_level=1, health_fail=0.
2. Fill: 5 words of alternating bits with no pops -> fifo_level=4, overflow_cnt=1. Then pop 4 times -> the 4 words read back in order, rd_valid=0; a further rd_pop leaves fifo_level=0.
3. Health trip: 7 consecutive 1s (RCT_CUTOFF=8) -> health_fail=0. The 8th 1 -> health_fail=1 next cycle, fifo_level unchanged, and further bits are ignored. clear_fail pulse -> health_fail=0, FSM goes to IDLE then COLLECT, and a fresh 32 alternating bits yield 0xAAAAAAAA.
4. Partial abort: 16 bits 1,0 alternating, enable=0 for 1 cycle, enable=1, then 32 bits 0,1 alternating -> the only word pushed is 0x55555555.
5. Full FIFO, rd_pop asserted on the same cycle the 32nd bit completes a word -> fifo_level stays 4, overflow_cnt unchanged, and the new word is last in order.
6. Async reset asserted mid-word and mid-FAIL with 3 words buffered -> all outputs are 0 immediately, with no clock edge required.
